// File: rtl/dff_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : dff_response_checker
// Description : Response monitor for a D flip-flop cell. It samples the
//               flop's D input and Q output on the flop's own clock and checks
//               that Q after each rising edge equals the D captured at that
//               edge. A run makes NUM_SAMPLES comparisons. The block then
//               holds Done with a Pass/Fail verdict, the sample count, the
//               mismatch count and the index of the first mismatch.
// Ports       : Clk           - rising-edge clock, shared with the flop
//               Rst_n         - asynchronous active-low reset
//               Start         - begin a run (honoured in IDLE and DONE only)
//               D_obs         - flop D input as seen at the flop
//               Q_obs         - flop Q output
//               Done          - high while the result is held
//               Pass          - Done and no mismatches
//               Fail          - Done and at least one mismatch
//               Sample_cnt    - comparisons made in the current/last run
//               Mismatch_cnt  - mismatches in the current/last run
//               First_err_idx - 0-based index of the first mismatch (valid
//                               only while Fail is high)
// Revision    : 1.0 - initial release
// ============================================================================
module dff_response_checker #(
  parameter int NUM_SAMPLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             D_obs,
  input  logic             Q_obs,
  output logic             Done,
  output logic             Pass,
  output logic             Fail,
  output logic [CNT_W-1:0] Sample_cnt,
  output logic [CNT_W-1:0] Mismatch_cnt,
  output logic [CNT_W-1:0] First_err_idx
);

  // Every counter must be able to hold NUM_SAMPLES, so the run length has to
  // fit in CNT_W bits and be at least one comparison long.
  if ((NUM_SAMPLES < 1) || (NUM_SAMPLES > ((2 ** CNT_W) - 1))) begin : g_param_check
    $error("dff_response_checker: NUM_SAMPLES=%0d is outside 1..2**CNT_W-1 (CNT_W=%0d)",
           NUM_SAMPLES, CNT_W);
  end

  // The run ends on the compare that sees this pre-increment sample count,
  // which is the same condition as "count after increment == NUM_SAMPLES".
  localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q,      state_d;
  logic             exp_q,        exp_d;
  logic             err_seen_q,   err_seen_d;
  logic [CNT_W-1:0] sample_q,     sample_d;
  logic [CNT_W-1:0] mismatch_q,   mismatch_d;
  logic [CNT_W-1:0] first_err_q,  first_err_d;

  // --------------------------------------------------------------------------
  // State and counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      exp_q       <= 1'b0;
      err_seen_q  <= 1'b0;
      sample_q    <= '0;
      mismatch_q  <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      err_seen_q  <= err_seen_d;
      sample_q    <= sample_d;
      mismatch_q  <= mismatch_d;
      first_err_q <= first_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    err_seen_d  = err_seen_q;
    sample_d    = sample_q;
    mismatch_d  = mismatch_q;
    first_err_d = first_err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // A new run starts from clean counters; the previous result is held
        // until this point.
        if (Start) begin
          state_d     = S_PRIME;
          err_seen_d  = 1'b0;
          sample_d    = '0;
          mismatch_d  = '0;
          first_err_d = '0;
        end
      end

      S_PRIME: begin
        // Capture the first D so the first compare has something to check
        // Q against one cycle later.
        exp_d   = D_obs;
        state_d = S_CHECK;
      end

      S_CHECK: begin
        // Q now reflects the edge at which exp_q was captured. The
        // case-inequality makes an unknown Q count as a mismatch.
        exp_d    = D_obs;
        sample_d = sample_q + c_ONE;
        if (Q_obs !== exp_q) begin
          mismatch_d = mismatch_q + c_ONE;
          if (!err_seen_q) begin
            first_err_d = sample_q;
            err_seen_d  = 1'b1;
          end
        end
        if (sample_q == c_LAST_IDX) begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registered state only
  // --------------------------------------------------------------------------
  assign Done          = (state_q == S_DONE);
  assign Pass          = Done && (mismatch_q == '0);
  assign Fail          = Done && (mismatch_q != '0);
  assign Sample_cnt    = sample_q;
  assign Mismatch_cnt  = mismatch_q;
  assign First_err_idx = first_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dff_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_response_checker
// Description : Directed bench for dff_response_checker. The bench contains a
//               behavioural flop whose Q can be replaced by stuck-at-0 or X.
//               Each run pushes an expected result into a scoreboard. The
//               result is popped and compared when Done rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_response_checker;

  localparam int NS = 8;
  localparam int CW = 8;

  typedef struct packed {
    logic          pass;
    logic          fail;
    logic [CW-1:0] samp;
    logic [CW-1:0] mis;
    logic [CW-1:0] ferr;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          d_obs;
  logic          q_obs;
  logic          done;
  logic          pass;
  logic          fail;
  logic [CW-1:0] sample_cnt;
  logic [CW-1:0] mismatch_cnt;
  logic [CW-1:0] first_err_idx;

  logic q_flop;
  int   q_mode;          // 0 ideal flop, 1 stuck at 0, 2 forced X
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  dff_response_checker #(
    .NUM_SAMPLES (NS),
    .CNT_W       (CW)
  ) dut (
    .Clk           (clk),
    .Rst_n         (rst_n),
    .Start         (start),
    .D_obs         (d_obs),
    .Q_obs         (q_obs),
    .Done          (done),
    .Pass          (pass),
    .Fail          (fail),
    .Sample_cnt    (sample_cnt),
    .Mismatch_cnt  (mismatch_cnt),
    .First_err_idx (first_err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flop under observation
  always @(posedge clk) q_flop <= d_obs;

  assign q_obs = (q_mode == 1) ? 1'b0 : (q_mode == 2) ? 1'bx : q_flop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result: compare i sees Q as the flop left it after the edge
  // where pat[i] was captured.
  function automatic exp_t model(input logic [8:0] pat, input int mode, input int xidx);
    exp_t r;
    logic qv;
    bit   seen;
    seen   = 1'b0;
    r.mis  = '0;
    r.ferr = '0;
    for (int i = 0; i < NS; i++) begin
      if (mode == 1)                    qv = 1'b0;
      else if (mode == 2 && i == xidx)  qv = 1'bx;
      else                              qv = pat[i];
      if (qv !== pat[i]) begin
        if (!seen) begin
          r.ferr = i[CW-1:0];
          seen   = 1'b1;
        end
        r.mis = r.mis + 1'b1;
      end
    end
    r.samp = CW'(NS);
    r.pass = (r.mis == '0);
    r.fail = (r.mis != '0);
    return r;
  endfunction

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".pass"},  pass,          e.pass);
      chk({tag, ".fail"},  fail,          e.fail);
      chk({tag, ".samp"},  sample_cnt,    e.samp);
      chk({tag, ".mis"},   mismatch_cnt,  e.mis);
      chk({tag, ".ferr"},  first_err_idx, e.ferr);
    end
  endtask

  // One run with Start pulsed for one cycle. pat[e] is driven on D for edge
  // e+1 (edge 0 being the Start edge). restart_e re-pulses Start after edge
  // restart_e while the run is in progress.
  task automatic run_one(input string tag, input logic [8:0] pat, input int mode,
                         input int xidx, input int restart_e);
    int base;
    base = (mode == 1) ? 1 : 0;
    sb.push_back(model(pat, mode, xidx));
    @(negedge clk);
    start  = 1'b1;
    d_obs  = 1'($urandom);
    q_mode = base;
    @(negedge clk);
    start  = 1'b0;
    d_obs  = pat[0];
    chk({tag, ".start_done"}, done,         32'd0);
    chk({tag, ".start_samp"}, sample_cnt,   32'd0);
    chk({tag, ".start_mis"},  mismatch_cnt, 32'd0);
    for (int e = 1; e <= NS; e++) begin
      @(negedge clk);
      d_obs  = pat[e];
      start  = (e == restart_e);
      q_mode = (mode == 2 && e == xidx + 1) ? 2 : base;
      if (e >= 2) chk({tag, ".run_samp"}, sample_cnt, e - 1);
      chk({tag, ".run_done"}, done, 32'd0);
    end
    @(negedge clk);
    start  = 1'b0;
    q_mode = base;
    chk({tag, ".done"}, done, 32'd1);
    check_result(tag);
    q_mode = 0;
  endtask

  initial begin : stim
    int last_c;
    int pulses;
    exp_t ideal;

    rst_n  = 1'b0;
    start  = 1'b0;
    d_obs  = 1'b0;
    q_mode = 0;

    // Reset state
    #3;
    chk("rst.done", done,          32'd0);
    chk("rst.pass", pass,          32'd0);
    chk("rst.fail", fail,          32'd0);
    chk("rst.samp", sample_cnt,    32'd0);
    chk("rst.mis",  mismatch_cnt,  32'd0);
    chk("rst.ferr", first_err_idx, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Ideal flop, D toggling
    run_one("t1_ideal", 9'b101010101, 0, 0, 0);

    // Q stuck at 0, D = 0,1,0,1,...
    run_one("t2_stuck0", 9'b010101010, 1, 0, 0);
    @(negedge clk);
    chk("t2_hold.done", done,         32'd1);
    chk("t2_hold.mis",  mismatch_cnt, 32'd4);

    // Q forced to X at compare index 5 (D there is 1)
    run_one("t6_xq", 9'b011101100, 2, 5, 0);

    // Start re-pulsed mid-run is ignored; a pulse in DONE restarts cleanly
    run_one("t4_restart", 9'($urandom), 0, 0, 4);
    run_one("t4_again",   9'($urandom), 1, 0, 0);

    // Async reset part-way through CHECK, Q stuck at 0 against D=1
    @(negedge clk);
    start  = 1'b1;
    d_obs  = 1'b1;
    q_mode = 1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t3_pre.samp", sample_cnt,   32'd3);
    chk("t3_pre.mis",  mismatch_cnt, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t3.done", done,          32'd0);
    chk("t3.pass", pass,          32'd0);
    chk("t3.fail", fail,          32'd0);
    chk("t3.samp", sample_cnt,    32'd0);
    chk("t3.mis",  mismatch_cnt,  32'd0);
    chk("t3.ferr", first_err_idx, 32'd0);
    #1 rst_n = 1'b1;
    q_mode = 0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_idle.samp", sample_cnt, 32'd0);
      chk("t3_idle.done", done,       32'd0);
    end

    // Start held high: back-to-back runs, one-cycle Done per run
    ideal = model(9'b000000000, 0, 0);
    repeat (3) sb.push_back(ideal);
    start  = 1'b1;
    last_c = -1;
    pulses = 0;
    for (int c = 0; c < 3 * (NS + 2) + 15 && pulses < 3; c++) begin
      @(negedge clk);
      d_obs = 1'($urandom);
      if (done) begin
        if (last_c >= 0) chk("t5.gap", c - last_c, NS + 2);
        check_result("t5");
        last_c = c;
        pulses++;
      end
    end
    chk("t5.pulses", pulses, 32'd3);
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
